// File: rtl/configregpwm_shadow.sv
// configregpwm_shadow
// Double-buffered PWM channel configuration. Writes land in a per-channel shadow
// register; the shadow is promoted to the active register immediately or on a
// carrier event chosen by the shadow's upd_mode, so a running PWM period never sees
// a half-applied mode change. A write that turns PWM off is honoured at once.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   wr_en/wr_ch/wr_data  single-cycle config write (wr_ch >= NCH is dropped)
//   evt_zero/evt_top     per-channel carrier events (counter at zero / at period)
//   force_upd            promote every pending shadow now
//   rd_ch/rd_shadow      combinational readback select
//   rd_data              {0, pending[rd_ch] @ bit 10, selected reg[9:0]}
//   pending              shadow not yet applied, per channel
//   count_mode .. pwm_onoff  decoded fields of the active register
//
// Word map: [1:0] count_mode, [3:2] mask_mode, [4] pwmclkdiv, [5] dtclkdiv,
//           [6] int, [7] pwm_onoff, [9:8] upd_mode (00 now, 01 zero, 10 top, 11 either)

`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module configregpwm_shadow #(
  parameter int NCH       = 4,
  parameter int REG_WIDTH = `PWMCOUNT_WIDTH,
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [REG_WIDTH-1:0] wr_data,
  input  logic [NCH-1:0]       evt_zero,
  input  logic [NCH-1:0]       evt_top,
  input  logic                 force_upd,
  input  logic [CHW-1:0]       rd_ch,
  input  logic                 rd_shadow,
  output logic [REG_WIDTH-1:0] rd_data,
  output logic [NCH-1:0]       pending,
  output logic [NCH-1:0][1:0]  count_mode,
  output logic [NCH-1:0][1:0]  mask_mode,
  output logic [NCH-1:0]       pwmclkdiv_onoff,
  output logic [NCH-1:0]       dtclkdiv_onoff,
  output logic [NCH-1:0]       int_onoff,
  output logic [NCH-1:0]       pwm_onoff
);

  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);
  // Pending flag lives at bit 10 when the bus is wide enough to carry it.
  localparam int PBIT = (REG_WIDTH > 10) ? 10 : 9;

  logic [NCH-1:0][9:0] r_shadow;
  logic [NCH-1:0][9:0] r_active;
  logic [NCH-1:0]      r_pending;

  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [NCH-1:0]       w_wr_hit;
  logic [NCH-1:0]       w_apply;
  logic [REG_WIDTH-1:0] w_rd_word;
  logic                 w_unused_wr_hi;

  // Bits above 9 of the write word carry no state.
  assign w_unused_wr_hi = ^wr_data;

  assign w_wr_ok = ({1'b0, wr_ch} < NCH_W);
  assign w_rd_ok = ({1'b0, rd_ch} < NCH_W);

  // Event qualification uses the shadow currently held, so a write landing in the
  // same cycle as an event cannot change which shadow gets promoted.
  always_comb begin
    w_wr_hit = '0;
    w_apply  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wr_hit[i] = wr_en && w_wr_ok && (wr_ch == CHW'(i));
      w_apply[i]  = r_pending[i] &&
                    (force_upd ||
                     (r_shadow[i][8] && evt_zero[i]) ||
                     (r_shadow[i][9] && evt_top[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_apply[i]) begin
          r_active[i]  <= r_shadow[i];
          r_pending[i] <= 1'b0;
        end
        // Later assignments override the promotion above: an immediate write wins,
        // and a pwm-off write always kills the output even if old data was promoted.
        if (w_wr_hit[i]) begin
          r_shadow[i] <= wr_data[9:0];
          if (wr_data[9:8] == 2'b00) begin
            r_active[i]  <= wr_data[9:0];
            r_pending[i] <= 1'b0;
          end else begin
            r_pending[i] <= 1'b1;
            if (!wr_data[7]) r_active[i][7] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
      w_rd_word[9:0] = rd_shadow ? r_shadow[rd_ch] : r_active[rd_ch];
      if (REG_WIDTH > 10) w_rd_word[PBIT] = r_pending[rd_ch];
    end
  end

  assign rd_data = w_rd_word;
  assign pending = r_pending;

  always_comb begin
    count_mode      = '0;
    mask_mode       = '0;
    pwmclkdiv_onoff = '0;
    dtclkdiv_onoff  = '0;
    int_onoff       = '0;
    pwm_onoff       = '0;
    for (int i = 0; i < NCH; i++) begin
      count_mode[i]      = r_active[i][1:0];
      mask_mode[i]       = r_active[i][3:2];
      pwmclkdiv_onoff[i] = r_active[i][4];
      dtclkdiv_onoff[i]  = r_active[i][5];
      int_onoff[i]       = r_active[i][6];
      pwm_onoff[i]       = r_active[i][7];
    end
  end

endmodule

// File: tb/tb_configregpwm_shadow.sv
module tb_configregpwm_shadow;

  localparam int NCH = 5;
  localparam int RW  = 16;
  localparam int CHW = 3;
  localparam int OW  = 9 * NCH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_en = 1'b0;
  logic [CHW-1:0]       wr_ch = '0;
  logic [RW-1:0]        wr_data = '0;
  logic [NCH-1:0]       evt_zero = '0;
  logic [NCH-1:0]       evt_top = '0;
  logic                 force_upd = 1'b0;
  logic [CHW-1:0]       rd_ch = '0;
  logic                 rd_shadow = 1'b0;
  logic [RW-1:0]        rd_data;
  logic [NCH-1:0]       pending;
  logic [NCH-1:0][1:0]  count_mode;
  logic [NCH-1:0][1:0]  mask_mode;
  logic [NCH-1:0]       pwmclkdiv_onoff;
  logic [NCH-1:0]       dtclkdiv_onoff;
  logic [NCH-1:0]       int_onoff;
  logic [NCH-1:0]       pwm_onoff;

  int total = 0;
  int bad   = 0;

  configregpwm_shadow #(.NCH(NCH), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .evt_zero(evt_zero), .evt_top(evt_top), .force_upd(force_upd),
    .rd_ch(rd_ch), .rd_shadow(rd_shadow), .rd_data(rd_data), .pending(pending),
    .count_mode(count_mode), .mask_mode(mask_mode),
    .pwmclkdiv_onoff(pwmclkdiv_onoff), .dtclkdiv_onoff(dtclkdiv_onoff),
    .int_onoff(int_onoff), .pwm_onoff(pwm_onoff)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel shadow word, active word and pending flag.
  bit [9:0] m_sh   [NCH];
  bit [9:0] m_act  [NCH];
  bit       m_pend [NCH];

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = '0; m_act[i] = '0; m_pend[i] = 1'b0;
    end
  endfunction

  // One clock edge: pending channels whose event matches the stored update mode
  // (or force) take their stored shadow; then the write is applied on top.
  function automatic void model_edge(bit we, int ch, bit [RW-1:0] d,
                                     bit [NCH-1:0] ez, bit [NCH-1:0] et, bit fu);
    for (int i = 0; i < NCH; i++) begin
      int um = int'(m_sh[i][9:8]);
      bit on_zero = (um == 1) || (um == 3);
      bit on_top  = (um == 2) || (um == 3);
      if (m_pend[i] && (fu || (ez[i] && on_zero) || (et[i] && on_top))) begin
        m_act[i]  = m_sh[i];
        m_pend[i] = 1'b0;
      end
    end
    if (we && ch < NCH) begin
      m_sh[ch] = d[9:0];
      if (d[9:8] == 2'b00) begin
        m_act[ch]  = d[9:0];
        m_pend[ch] = 1'b0;
      end else begin
        m_pend[ch] = 1'b1;
        if (d[7] == 1'b0) m_act[ch][7] = 1'b0;
      end
    end
  endfunction

  function automatic logic [OW-1:0] model_obs();
    logic [NCH-1:0] e_pend, e_pwm, e_int, e_dt, e_pc;
    logic [NCH-1:0][1:0] e_mask, e_cnt;
    for (int i = 0; i < NCH; i++) begin
      e_pend[i] = m_pend[i];
      e_cnt[i]  = m_act[i][1:0];
      e_mask[i] = m_act[i][3:2];
      e_pc[i]   = m_act[i][4];
      e_dt[i]   = m_act[i][5];
      e_int[i]  = m_act[i][6];
      e_pwm[i]  = m_act[i][7];
    end
    return {e_pend, e_pwm, e_int, e_dt, e_pc, e_mask, e_cnt};
  endfunction

  function automatic logic [RW-1:0] model_rd(int ch, bit sh);
    logic [RW-1:0] r = '0;
    if (ch < NCH) begin
      r[9:0] = sh ? m_sh[ch] : m_act[ch];
      r[10]  = m_pend[ch];
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] dut_obs();
    return {pending, pwm_onoff, int_onoff, dtclkdiv_onoff, pwmclkdiv_onoff,
            mask_mode, count_mode};
  endfunction

  // Drive one cycle of inputs, advance through the edge, update the model.
  task automatic step(bit we, int ch, bit [RW-1:0] d,
                      bit [NCH-1:0] ez, bit [NCH-1:0] et, bit fu);
    wr_en = we; wr_ch = CHW'(ch); wr_data = d;
    evt_zero = ez; evt_top = et; force_upd = fu;
    @(posedge clk);
    model_edge(we, ch, d, ez, et, fu);
    #1;
    wr_en = 1'b0; evt_zero = '0; evt_top = '0; force_upd = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut_obs() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", dut_obs());
    end
    for (int c = 0; c < NCH; c++) begin
      rd_ch = CHW'(c); rd_shadow = c[0]; #1;
      total++;
      if (rd_data !== '0) begin
        bad++; $display("FAIL reset_rd ch=%0d got=%h want=0", c, rd_data);
      end
    end
  endtask

  task automatic test_immediate();
    step(1'b1, 0, 16'h00C1, '0, '0, 1'b0);
    total++;
    if (pwm_onoff[0] !== 1'b1 || count_mode[0] !== 2'b01 || pending[0] !== 1'b0) begin
      bad++; $display("FAIL imm_ch0 got pwm=%b cnt=%b pend=%b want 1 01 0",
                      pwm_onoff[0], count_mode[0], pending[0]);
    end
    total++;
    if (dut_obs() !== model_obs()) begin
      bad++; $display("FAIL imm_obs got=%h want=%h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_event_zero();
    step(1'b1, 1, 16'h01A5, '0, '0, 1'b0);
    total++;
    if (pending[1] !== 1'b1 || pwm_onoff[1] !== 1'b0 || count_mode[1] !== 2'b00) begin
      bad++; $display("FAIL ev_pend got pend=%b pwm=%b cnt=%b want 1 0 00",
                      pending[1], pwm_onoff[1], count_mode[1]);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 0, '0, '0, NCH'(2), 1'b0);
      total++;
      if (dut_obs() !== model_obs() || pending[1] !== 1'b1 || mask_mode[1] !== 2'b00) begin
        bad++; $display("FAIL ev_top_ignored k=%0d got=%h want=%h", k, dut_obs(), model_obs());
      end
    end
    step(1'b0, 0, '0, NCH'(2), '0, 1'b0);
    total++;
    if (pending[1] !== 1'b0 || count_mode[1] !== 2'b01 || mask_mode[1] !== 2'b01 ||
        dtclkdiv_onoff[1] !== 1'b1 || int_onoff[1] !== 1'b0 || pwm_onoff[1] !== 1'b1) begin
      bad++; $display("FAIL ev_zero_apply got=%h want=%h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_safety();
    step(1'b1, 2, 16'h0080, '0, '0, 1'b0);
    step(1'b1, 2, 16'h0344, '0, '0, 1'b0);
    total++;
    if (pwm_onoff[2] !== 1'b0 || mask_mode[2] !== 2'b00 || pending[2] !== 1'b1) begin
      bad++; $display("FAIL safe_off got pwm=%b mask=%b pend=%b want 0 00 1",
                      pwm_onoff[2], mask_mode[2], pending[2]);
    end
    step(1'b0, 0, '0, '0, NCH'(8), 1'b0);
    total++;
    if (mask_mode[2] !== 2'b00 || pending[2] !== 1'b1) begin
      bad++; $display("FAIL safe_other_evt got mask=%b pend=%b want 00 1",
                      mask_mode[2], pending[2]);
    end
    step(1'b0, 0, '0, '0, NCH'(4), 1'b0);
    total++;
    if (mask_mode[2] !== 2'b01 || int_onoff[2] !== 1'b1 || pending[2] !== 1'b0 ||
        dut_obs() !== model_obs()) begin
      bad++; $display("FAIL safe_apply got=%h want=%h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_collision();
    step(1'b1, 3, 16'h01C2, '0, '0, 1'b0);
    step(1'b1, 3, 16'h02B3, NCH'(8), '0, 1'b0);
    total++;
    if (count_mode[3] !== 2'b10 || pwm_onoff[3] !== 1'b1 || int_onoff[3] !== 1'b1 ||
        pending[3] !== 1'b1) begin
      bad++; $display("FAIL coll_old_applied got=%h want=%h", dut_obs(), model_obs());
    end
    rd_ch = 3'd3; rd_shadow = 1'b1; #1;
    total++;
    if (rd_data !== 16'h06B3) begin
      bad++; $display("FAIL coll_rd_shadow got=%h want=06B3", rd_data);
    end
    rd_shadow = 1'b0; #1;
    total++;
    if (rd_data !== model_rd(3, 1'b0)) begin
      bad++; $display("FAIL coll_rd_active got=%h want=%h", rd_data, model_rd(3, 1'b0));
    end
  endtask

  task automatic test_force();
    for (int c = 0; c < 4; c++)
      step(1'b1, c, {6'b0, 2'b10, 8'($urandom)}, '0, '0, 1'b0);
    total++;
    if (pending[3:0] !== 4'hF) begin
      bad++; $display("FAIL force_pend4 got=%b want=1111", pending[3:0]);
    end
    step(1'b1, NCH, 16'h00FF, '0, '0, 1'b0);
    step(1'b1, 7, 16'h00AA, '0, '0, 1'b0);
    total++;
    if (dut_obs() !== model_obs()) begin
      bad++; $display("FAIL bad_ch_write got=%h want=%h", dut_obs(), model_obs());
    end
    rd_ch = 3'd6; rd_shadow = 1'b1; #1;
    total++;
    if (rd_data !== '0) begin
      bad++; $display("FAIL rd_out_of_range got=%h want=0", rd_data);
    end
    step(1'b0, 0, '0, '0, '0, 1'b1);
    total++;
    if (pending !== '0 || dut_obs() !== model_obs()) begin
      bad++; $display("FAIL force_apply got=%h want=%h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit we = ($urandom_range(0, 2) != 0);
      int ch = $urandom_range(0, 7);
      bit [RW-1:0] d = RW'($urandom);
      bit [NCH-1:0] ez = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      bit [NCH-1:0] et = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      bit fu = ($urandom_range(0, 15) == 0);
      int rc;
      step(we, ch, d, ez, et, fu);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++; $display("FAIL rand_obs n=%0d got=%h want=%h", n, dut_obs(), model_obs());
      end
      rc = $urandom_range(0, 7);
      rd_ch = CHW'(rc); rd_shadow = 1'($urandom);
      #1;
      total++;
      if (rd_data !== model_rd(rc, rd_shadow)) begin
        bad++; $display("FAIL rand_rd n=%0d ch=%0d got=%h want=%h",
                        n, rc, rd_data, model_rd(rc, rd_shadow));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < NCH; c++)
      step(1'b1, c, 16'h01FF, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (dut_obs() !== '0) begin
      bad++; $display("FAIL async_rst_obs got=%h want=0", dut_obs());
    end
    for (int s = 0; s < 2; s++) begin
      rd_ch = 3'd1; rd_shadow = s[0]; #1;
      total++;
      if (rd_data !== '0) begin
        bad++; $display("FAIL async_rst_rd sh=%0d got=%h want=0", s, rd_data);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 0, '0, '1, '1, 1'b1);
    total++;
    if (dut_obs() !== '0) begin
      bad++; $display("FAIL post_rst_no_pending got=%h want=0", dut_obs());
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_event_zero();
    test_safety();
    test_collision();
    test_force();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
